immgen_pipe: RTL

- Pipelined, parametrised immediate generator for the decode stage of the RISC-V core; generalises the combinational immediate unit.
- Accepts 32-bit instructions over a valid/ready handshake and classifies each by opcode.
- Produces a sign-extended XLEN immediate, a one-hot format tag and an illegal flag, buffered in a DEPTH-entry output FIFO.
- Keeps a saturating count of illegal encodings for debug.

---
 rtl/immgen_pipe.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/immgen_pipe.sv
// immgen_pipe: pipelined RISC-V immediate generator for the decode stage.
// Each accepted instruction is decoded combinationally and written into a
// DEPTH-entry output FIFO. Every entry holds the sign-extended immediate, a
// one-hot format tag and an illegal flag. Illegal encodings are queued in
// order, with a zero immediate and a zero tag, and they are counted in a
// saturating debug counter.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   in_valid/ready  input handshake for in_inst (32-bit instruction word)
//   out_valid/ready output handshake for the FIFO head
//   out_imm         XLEN immediate (zero-extended shamt for shifts)
//   out_type        one-hot {J,U,B,S,SH,I}; zero when illegal
//   out_illegal     head entry was an unsupported or illegal encoding
//   illegal_cnt     saturating count of accepted illegal words
module immgen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [5:0]       out_type,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [5:0] T_J  = 6'b100000;
  localparam logic [5:0] T_U  = 6'b010000;
  localparam logic [5:0] T_B  = 6'b001000;
  localparam logic [5:0] T_S  = 6'b000100;
  localparam logic [5:0] T_SH = 6'b000010;
  localparam logic [5:0] T_I  = 6'b000001;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Sign-extends a 32-bit value to XLEN bits. The widening is done with a
  // fill-then-overwrite so that XLEN=32 needs no zero-width replication.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dec_imm;
  logic [5:0]      dec_type;
  logic            dec_ill;
  logic [31:0]     i_imm;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign i_imm  = {{20{in_inst[31]}}, in_inst[31:20]};

  always_comb begin
    dec_imm  = '0;
    dec_type = '0;
    dec_ill  = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_type = T_SH;
          if (XLEN == 32) begin
            dec_imm[4:0] = in_inst[24:20];
            if (in_inst[25]) dec_ill = 1'b1;
          end else begin
            dec_imm[5:0] = in_inst[25:20];
          end
          if (funct3 == 3'b001 && in_inst[31:26] != 6'b000000) dec_ill = 1'b1;
          if (funct3 == 3'b101 && in_inst[31:26] != 6'b000000 &&
              in_inst[31:26] != 6'b010000) dec_ill = 1'b1;
        end else begin
          dec_type = T_I;
          dec_imm  = sext32(i_imm);
        end
      end
      OP_LOAD: begin
        dec_type = T_I;
        dec_imm  = sext32(i_imm);
      end
      OP_JALR: begin
        dec_type = T_I;
        dec_imm  = sext32(i_imm);
        if (funct3 != 3'b000) dec_ill = 1'b1;
      end
      OP_IMM_32: begin
        if (XLEN == 32) begin
          dec_ill = 1'b1;
        end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_type     = T_SH;
          dec_imm[4:0] = in_inst[24:20];
          if (in_inst[25]) dec_ill = 1'b1;
        end else if (funct3 == 3'b000) begin
          dec_type = T_I;
          dec_imm  = sext32(i_imm);
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_STORE: begin
        dec_type = T_S;
        dec_imm  = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
      end
      OP_BRANCH: begin
        dec_type = T_B;
        dec_imm  = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0});
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_ill = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_type = T_U;
        dec_imm  = sext32({in_inst[31:12], 12'b0});
      end
      OP_JAL: begin
        dec_type = T_J;
        dec_imm  = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0});
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal entries carry no immediate and no format tag.
    if (dec_ill) begin
      dec_imm  = '0;
      dec_type = '0;
    end
  end

  logic [XLEN-1:0]  imm_mem_q  [DEPTH];
  logic [XLEN-1:0]  imm_mem_d  [DEPTH];
  logic [5:0]       type_mem_q [DEPTH];
  logic [5:0]       type_mem_d [DEPTH];
  logic             ill_mem_q  [DEPTH];
  logic             ill_mem_d  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = (cnt_q != '0) && out_ready;

  always_comb begin
    imm_mem_d  = imm_mem_q;
    type_mem_d = type_mem_q;
    ill_mem_d  = ill_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ill_cnt_d  = ill_cnt_q;
    if (push) begin
      imm_mem_d[wr_ptr_q]  = dec_imm;
      type_mem_d[wr_ptr_q] = dec_type;
      ill_mem_d[wr_ptr_q]  = dec_ill;
      wr_ptr_d             = wr_ptr_q + PW'(1);
      if (dec_ill && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Registered ready: reflects occupancy after this edge, so a pop can
    // never open the input in the same cycle it happens.
    in_ready_d = (cnt_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_mem_q  <= '{default: '0};
      type_mem_q <= '{default: '0};
      ill_mem_q  <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      ill_cnt_q  <= '0;
    end else begin
      imm_mem_q  <= imm_mem_d;
      type_mem_q <= type_mem_d;
      ill_mem_q  <= ill_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (cnt_q != '0);
  assign out_imm     = imm_mem_q[rd_ptr_q];
  assign out_type    = type_mem_q[rd_ptr_q];
  assign out_illegal = ill_mem_q[rd_ptr_q];
  assign illegal_cnt = ill_cnt_q;

endmodule
